// File: rtl/arm_dp_exec_core.sv
// Execution core for the phase-1 ARM datapath: ALU with extended micro-ops,
// condition-code tester and the microcoded control unit that drives the datapath.
module arm_dp_exec_core (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IR,
    input  logic        MOC,
    input  logic        LSM_DETECT,
    input  logic        LSM_END,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  FR_Q,
    output logic [33:0] CU_OUT,
    output logic [3:0]  STATE,
    output logic [31:0] ALU_OUT,
    output logic [3:0]  FLAGS,
    output logic        COND_OUT
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_PCINC  = 4'd2,
        S_IRLOAD = 4'd3,
        S_DECODE = 4'd4,
        S_DPREG  = 4'd10,
        S_DPIMM  = 4'd11
    } state_t;

    state_t state_q, state_d;

    logic        flagC, flagZ, flagV, flagN;
    logic        isDataProc;
    logic [4:0]  aluOp;
    logic [31:0] addX, addY;
    logic        addCin;
    logic        isArith;
    logic [32:0] sumFull;
    logic        unusedBits;

    // Load/store-multiple hooks and register-field bits are not consumed here.
    assign unusedBits = ^{LSM_DETECT, LSM_END, IR[19:8], IR[6:5], IR[3:0]};

    assign flagC = FR_Q[3];
    assign flagZ = FR_Q[2];
    assign flagV = FR_Q[1];
    assign flagN = FR_Q[0];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    assign STATE = state_q;

    always_comb begin
        COND_OUT = 1'b0;
        case (IR[31:28])
            4'd0:    COND_OUT = flagZ;
            4'd1:    COND_OUT = !flagZ;
            4'd2:    COND_OUT = flagC;
            4'd3:    COND_OUT = !flagC;
            4'd4:    COND_OUT = flagN;
            4'd5:    COND_OUT = !flagN;
            4'd6:    COND_OUT = flagV;
            4'd7:    COND_OUT = !flagV;
            4'd8:    COND_OUT = flagC && !flagZ;
            4'd9:    COND_OUT = !flagC || flagZ;
            4'd10:   COND_OUT = (flagN == flagV);
            4'd11:   COND_OUT = (flagN != flagV);
            4'd12:   COND_OUT = !flagZ && (flagN == flagV);
            4'd13:   COND_OUT = flagZ || (flagN != flagV);
            4'd14:   COND_OUT = 1'b1;
            default: COND_OUT = 1'b0;
        endcase
    end

    // Multiply-class encodings (register form with bits 7 and 4 set) are not data processing.
    assign isDataProc = (IR[27:26] == 2'b00) && !(!IR[25] && IR[7] && IR[4]);

    always_comb begin
        state_d = S_RESET;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = S_PCINC;
            S_PCINC:  state_d = S_IRLOAD;
            S_IRLOAD: state_d = MOC ? S_DECODE : S_IRLOAD;
            S_DECODE: begin
                if (COND_OUT && isDataProc) begin
                    state_d = IR[25] ? S_DPIMM : S_DPREG;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DPREG,
            S_DPIMM:  state_d = S_FETCH;
            default:  state_d = S_RESET;
        endcase
    end

    always_comb begin
        CU_OUT = '0;
        case (state_q)
            S_FETCH: begin
                CU_OUT[30]    = 1'b1;
                CU_OUT[26:25] = 2'b01;
                CU_OUT[15:11] = 5'b10000;
            end
            S_PCINC: begin
                CU_OUT[32]    = 1'b1;
                CU_OUT[28]    = 1'b1;
                CU_OUT[27]    = 1'b1;
                CU_OUT[26:25] = 2'b01;
                CU_OUT[21:19] = 3'b001;
                CU_OUT[15:11] = 5'b10001;
            end
            S_IRLOAD: begin
                CU_OUT[31] = 1'b1;
                CU_OUT[28] = 1'b1;
                CU_OUT[27] = 1'b1;
            end
            S_DPREG,
            S_DPIMM: begin
                // Compare/test opcodes only update flags, never the destination register.
                CU_OUT[33]    = IR[20];
                CU_OUT[32]    = (IR[24:23] != 2'b10);
                CU_OUT[26:25] = 2'b00;
                CU_OUT[24:22] = 3'b001;
                CU_OUT[21:19] = 3'b011;
                CU_OUT[15:11] = {1'b0, IR[24:21]};
            end
            default: CU_OUT = '0;
        endcase
    end

    assign aluOp   = CU_OUT[15:11];
    assign sumFull = {1'b0, addX} + {1'b0, addY} + {32'b0, addCin};

    // Subtractions run through the adder as X + ~Y + carry so C becomes NOT borrow.
    always_comb begin
        addX    = B;
        addY    = A;
        addCin  = 1'b0;
        isArith = 1'b0;
        ALU_OUT = '0;
        case (aluOp)
            5'd0, 5'd8:  ALU_OUT = B & A;
            5'd1, 5'd9:  ALU_OUT = B ^ A;
            5'd2, 5'd10: begin
                isArith = 1'b1;
                addY    = ~A;
                addCin  = 1'b1;
                ALU_OUT = sumFull[31:0];
            end
            5'd3: begin
                isArith = 1'b1;
                addX    = A;
                addY    = ~B;
                addCin  = 1'b1;
                ALU_OUT = sumFull[31:0];
            end
            5'd4, 5'd11: begin
                isArith = 1'b1;
                ALU_OUT = sumFull[31:0];
            end
            5'd5: begin
                isArith = 1'b1;
                addCin  = flagC;
                ALU_OUT = sumFull[31:0];
            end
            5'd6: begin
                isArith = 1'b1;
                addY    = ~A;
                addCin  = flagC;
                ALU_OUT = sumFull[31:0];
            end
            5'd7: begin
                isArith = 1'b1;
                addX    = A;
                addY    = ~B;
                addCin  = flagC;
                ALU_OUT = sumFull[31:0];
            end
            5'd12:   ALU_OUT = B | A;
            5'd13:   ALU_OUT = A;
            5'd14:   ALU_OUT = B & ~A;
            5'd15:   ALU_OUT = ~A;
            5'd16:   ALU_OUT = B;
            5'd17:   ALU_OUT = B + 32'd4;
            5'd18:   ALU_OUT = A;
            5'd19:   ALU_OUT = A + B;
            default: ALU_OUT = '0;
        endcase
    end

    always_comb begin
        FLAGS[3] = isArith ? sumFull[32] : flagC;
        FLAGS[2] = (ALU_OUT == 32'd0);
        FLAGS[1] = isArith && (addX[31] == addY[31]) && (sumFull[31] != addX[31]);
        FLAGS[0] = ALU_OUT[31];
    end

endmodule

// File: tb/tb_arm_dp_exec_core.sv
// Scoreboard bench for arm_dp_exec_core: expectations are queued as stimulus is
// applied and compared against the DUT once its outputs have settled.
module tb_arm_dp_exec_core;

    logic        CLK;
    logic        RESET;
    logic [31:0] IR;
    logic        MOC;
    logic        LSM_DETECT;
    logic        LSM_END;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  FR_Q;
    logic [33:0] CU_OUT;
    logic [3:0]  STATE;
    logic [31:0] ALU_OUT;
    logic [3:0]  FLAGS;
    logic        COND_OUT;

    localparam int KSTATE = 0;
    localparam int KCU    = 1;
    localparam int KALU   = 2;
    localparam int KFLAGS = 3;
    localparam int KCOND  = 4;

    localparam logic [33:0] CU_FETCH  = 34'h0_4200_8000;
    localparam logic [33:0] CU_PCINC  = 34'h1_1A08_8800;
    localparam logic [33:0] CU_IRLOAD = 34'h0_9800_0000;

    typedef struct {
        string       tag;
        int          kind;
        logic [33:0] value;
    } expT;

    expT sbQ[$];
    int  assertCount = 0;
    int  failCount   = 0;

    arm_dp_exec_core dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IR         (IR),
        .MOC        (MOC),
        .LSM_DETECT (LSM_DETECT),
        .LSM_END    (LSM_END),
        .A          (A),
        .B          (B),
        .FR_Q       (FR_Q),
        .CU_OUT     (CU_OUT),
        .STATE      (STATE),
        .ALU_OUT    (ALU_OUT),
        .FLAGS      (FLAGS),
        .COND_OUT   (COND_OUT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [33:0] observe(int kind);
        case (kind)
            KSTATE:  return {30'b0, STATE};
            KCU:     return CU_OUT;
            KALU:    return {2'b0, ALU_OUT};
            KFLAGS:  return {30'b0, FLAGS};
            default: return {33'b0, COND_OUT};
        endcase
    endfunction

    // Reference ALU in wide integer arithmetic; returns {C,Z,V,N,result}.
    function automatic logic [35:0] refAlu(int op, logic [31:0] a, logic [31:0] b, logic cin);
        logic [31:0] f, s, r;
        longint      uf, sf, ex;
        logic        c, v;
        int          kind;
        f = '0; s = '0; r = '0; ex = 0; kind = 0; c = cin; v = 1'b0; uf = 0; sf = 0;
        case (op)
            0, 8:   r = b & a;
            1, 9:   r = b ^ a;
            2, 10:  begin kind = 2; f = b; s = a; end
            3:      begin kind = 2; f = a; s = b; end
            4, 11:  begin kind = 1; f = b; s = a; end
            5:      begin kind = 1; f = b; s = a; ex = cin ? 1 : 0; end
            6:      begin kind = 2; f = b; s = a; ex = cin ? 0 : 1; end
            7:      begin kind = 2; f = a; s = b; ex = cin ? 0 : 1; end
            12:     r = b | a;
            13:     r = a;
            14:     r = b & ~a;
            15:     r = ~a;
            16:     r = b;
            17:     r = b + 32'd4;
            18:     r = a;
            19:     r = a + b;
            default: r = '0;
        endcase
        if (kind == 1) begin
            uf = {32'b0, f} + {32'b0, s} + ex;
            sf = {{32{f[31]}}, f} + {{32{s[31]}}, s} + ex;
            c  = uf[32];
        end else if (kind == 2) begin
            uf = {32'b0, f} - {32'b0, s} - ex;
            sf = {{32{f[31]}}, f} - {{32{s[31]}}, s} - ex;
            c  = (uf >= 0);
        end
        if (kind != 0) begin
            r = uf[31:0];
            v = (sf != {{32{uf[31]}}, uf[31:0]});
        end
        return {c, (r == 32'd0), v, r[31], r};
    endfunction

    function automatic logic condModel(logic [3:0] code, logic [3:0] f);
        logic c, z, v, n;
        {c, z, v, n} = f;
        case (code)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [33:0] observed, input logic [33:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic pushExp(input string tag, input int kind, input logic [33:0] value);
        expT e;
        e.tag   = tag;
        e.kind  = kind;
        e.value = value;
        sbQ.push_back(e);
    endtask

    task automatic drainQueue();
        expT e;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput(e.tag, observe(e.kind), e.value);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] frq);
        IR   = ir;
        A    = a;
        B    = b;
        FR_Q = frq;
        #1;
    endtask

    // Assumes STATE=1 on entry; walks fetch up to decode with MOC held high.
    task automatic runFetch(input logic [31:0] ir);
        MOC = 1'b1;
        IR  = ir;
        #1;
        pushExp("fetch state1", KSTATE, 34'd1);
        pushExp("fetch cu1", KCU, CU_FETCH);
        drainQueue();
        tick();
        pushExp("fetch state2", KSTATE, 34'd2);
        pushExp("fetch cu2", KCU, CU_PCINC);
        drainQueue();
        tick();
        pushExp("fetch state3", KSTATE, 34'd3);
        pushExp("fetch cu3", KCU, CU_IRLOAD);
        drainQueue();
        tick();
        pushExp("decode state4", KSTATE, 34'd4);
        pushExp("decode cu", KCU, 34'd0);
        drainQueue();
    endtask

    task automatic dpInstr(input string tag, input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] frq, input logic [3:0] expState, input logic [33:0] expCu,
                           input logic [31:0] expAlu, input logic [3:0] expFlags);
        runFetch(ir);
        applyStimulus(ir, a, b, frq);
        pushExp({tag, " cond"}, KCOND, 34'd1);
        drainQueue();
        tick();
        pushExp({tag, " state"}, KSTATE, {30'b0, expState});
        pushExp({tag, " cu"}, KCU, expCu);
        pushExp({tag, " alu"}, KALU, {2'b0, expAlu});
        pushExp({tag, " flags"}, KFLAGS, {30'b0, expFlags});
        drainQueue();
        tick();
        pushExp({tag, " next"}, KSTATE, 34'd1);
        drainQueue();
    endtask

    task automatic skipInstr(input string tag, input logic [31:0] ir, input logic [3:0] frq, input logic expCond);
        runFetch(ir);
        FR_Q = frq;
        #1;
        pushExp({tag, " cond"}, KCOND, {33'b0, expCond});
        drainQueue();
        tick();
        pushExp({tag, " back to fetch"}, KSTATE, 34'd1);
        drainQueue();
    endtask

    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic        vc [3];

    initial begin
        logic [35:0] refOut;
        logic [31:0] ir;
        logic [33:0] cuExp;
        logic [3:0]  op4;

        va[0] = 32'h0000_000F; vb[0] = 32'h0000_00F0; vc[0] = 1'b1;
        va[1] = 32'h7FFF_FFFF; vb[1] = 32'h8000_0000; vc[1] = 1'b0;
        va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF; vc[2] = 1'b1;

        RESET = 1'b1; MOC = 1'b1; IR = '0; A = '0; B = '0; FR_Q = '0;
        LSM_DETECT = 1'b0; LSM_END = 1'b0;
        tick();
        tick();
        pushExp("reset state", KSTATE, 34'd0);
        pushExp("reset cu", KCU, 34'd0);
        drainQueue();

        RESET = 1'b0;
        tick();
        applyStimulus(32'hE29A_1001, 32'h1, 32'h100, 4'b0000);
        pushExp("state1", KSTATE, 34'd1);
        pushExp("cu fetch", KCU, CU_FETCH);
        pushExp("op16 passB", KALU, 34'h100);
        pushExp("op16 flags", KFLAGS, 34'h0);
        drainQueue();
        tick();
        pushExp("state2", KSTATE, 34'd2);
        pushExp("cu pcinc", KCU, CU_PCINC);
        pushExp("op17 B+4", KALU, 34'h104);
        pushExp("op17 flags", KFLAGS, 34'h0);
        drainQueue();

        MOC = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            pushExp("moc wait state", KSTATE, 34'd3);
            pushExp("moc wait cu", KCU, CU_IRLOAD);
            drainQueue();
        end
        MOC = 1'b1;
        tick();
        applyStimulus(32'hE29A_1001, 32'h1, 32'hFFFF_FFFF, 4'b0000);
        pushExp("moc done state", KSTATE, 34'd4);
        pushExp("decode cu", KCU, 34'd0);
        pushExp("adds cond", KCOND, 34'd1);
        drainQueue();
        tick();
        pushExp("adds imm state", KSTATE, 34'd11);
        pushExp("adds imm cu", KCU, 34'h3_0058_2000);
        pushExp("adds imm alu", KALU, 34'd0);
        pushExp("adds imm flags", KFLAGS, 34'hC);
        drainQueue();
        tick();
        pushExp("adds imm next", KSTATE, 34'd1);
        drainQueue();

        tick();
        RESET = 1'b1;
        tick();
        pushExp("abort state", KSTATE, 34'd0);
        pushExp("abort cu", KCU, 34'd0);
        drainQueue();
        RESET = 1'b0;
        tick();

        dpInstr("adds reg ovf", 32'hE098_C021, 32'h1, 32'h7FFF_FFFF, 4'b0000, 4'd10,
                34'h3_0058_2000, 32'h8000_0000, 4'b0011);
        dpInstr("cmp", 32'hE15A_0001, 32'h5, 32'h5, 4'b0000, 4'd10,
                34'h2_0058_5000, 32'h0, 4'b1100);
        dpInstr("eq pass", 32'h029A_1001, 32'h1, 32'hFFFF_FFFF, 4'b0100, 4'd11,
                34'h3_0058_2000, 32'h0, 4'b1100);
        skipInstr("eq fail", 32'h0A00_0000, 4'b0000, 1'b0);
        skipInstr("mul pattern", 32'hE000_0090, 4'b0000, 1'b1);
        skipInstr("ldr class", 32'hE590_0000, 4'b0000, 1'b1);

        for (int op = 0; op < 16; op++) begin
            for (int v = 0; v < 3; v++) begin
                op4    = op[3:0];
                ir     = {4'hE, 3'b001, op4, 1'b1, 20'h0};
                refOut = refAlu(op, va[v], vb[v], vc[v]);
                cuExp  = 34'h2_0058_0000;
                cuExp[14:11] = op4;
                cuExp[32]    = (op4[3:2] != 2'b10);
                dpInstr($sformatf("op%0d v%0d", op, v), ir, va[v], vb[v], {vc[v], 3'b000}, 4'd11,
                        cuExp, refOut[31:0], refOut[35:32]);
            end
        end

        for (int code = 0; code < 16; code++) begin
            for (int f = 0; f < 16; f++) begin
                IR   = {code[3:0], 28'h0};
                FR_Q = f[3:0];
                #1;
                pushExp($sformatf("cond%0d flags%0d", code, f), KCOND, {33'b0, condModel(code[3:0], f[3:0])});
                drainQueue();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/arm_dp_exec_core.md
# arm_dp_exec_core

Execution core for the phase-1 ARM datapath. It combines a 32-bit ALU with extended micro-ops, an ARM condition-code tester, and a microcoded control unit. The control unit emits the 34-bit datapath control word for instruction fetch and data-processing execution. It sits between the instruction register, register file, shifter/operand mux and flag register; memory behaviour is modelled only through the MOC handshake.

## Interface
- No parameters.
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-high reset.
- IR  input  32  current instruction.
- MOC  input  1  memory-operation-complete.
- LSM_DETECT, LSM_END  input  1 each  reserved; no effect in this block.
- A  input  32  ALU operand A (operand-B mux output / shifter operand).
- B  input  32  ALU operand B (register-file port A, Rn).
- FR_Q  input  4  stored flags {C,Z,V,N}; FR_Q[3] is the ALU carry-in.
- CU_OUT  output  34  control word.
- STATE  output  4  current control state.
- ALU_OUT  output  32  ALU result.
- FLAGS  output  4  new flags {C,Z,V,N}.
- COND_OUT  output  1  condition IR[31:28] satisfied by FR_Q.

## Operation
- CU_OUT fields: [33] FRLd, [32] RFLd, [31] IRLd, [30] MARLd, [29] MDRLd, [28] R/W (1=read), [27] MOV, [26:25] MA, [24:22] MB, [21:19] MC, [18:17] MD, [16] ME, [15:11] OP, [10] SLS_EN, [9:7] MS, [6] LSM_EN, [5:3] LSM_IN, [2:1] MH, [0] MF. Unlisted fields are 0 in every state.
- The ALU op is CU_OUT[15:11]. Ops 0–15 are ARM opcodes, with Rn=B and operand2=A:
  - AND, EOR, B−A, A−B, B+A, B+A+C, B−A−!C, A−B−!C.
  - TST, TEQ, CMP, CMN (same arithmetic as AND, EOR, SUB, ADD).
  - ORR, MOV (=A), BIC (B&~A), MVN (~A).
- Extended ALU ops: 16 = pass B; 17 = B+4; 18 = pass A; 19 = A+B without carry-in; 20–31 give result 0.
- Flags:
  - N = result[31]; Z = (result==0).
  - Add: C = carry-out, V = signed overflow.
  - Subtract: C = NOT borrow, V = signed overflow.
  - Logical, move and extended ops: C = carry-in, V = 0.
- COND_OUT uses standard ARM codes 0–14 (EQ…AL); code 15 gives 0.
- States:
  - 0 Reset: CU_OUT=0; next state 1.
  - 1 Fetch-MAR: MA=01, OP=10000, MARLd=1; next state 2.
  - 2 PC+4: MA=01, OP=10001, MC=001, RFLd=1, R/W=1, MOV=1; next state 3.
  - 3 IR load: R/W=1, MOV=1, IRLd=1; stays in 3 while MOC=0, goes to 4 when MOC=1.
  - 4 Decode: CU_OUT=0.
    - COND_OUT=0 → state 1.
    - IR[27:26]=00 and not (IR[25]=0, IR[7]=1, IR[4]=1) → state 11 if IR[25]=1, else state 10.
    - Otherwise → state 1.
  - 10 DP-register and 11 DP-immediate (identical control word):
    - MA=00, MB=001, MC=011, OP={0,IR[24:21]}.
    - RFLd=1 unless IR[24:23]=10 (TST/TEQ/CMP/CMN).
    - FRLd=IR[20].
    - Next state 1.
- Any state code not listed above goes to state 0 on the next edge.

## Timing
- STATE is a register updated on the CLK rising edge. RESET has priority over all transitions: STATE=0 at the edge.
- CU_OUT is combinational from STATE and IR. It reads all-zero while STATE=0.
- ALU_OUT, FLAGS and COND_OUT are combinational with zero latency.
- Minimum instruction time is 5 cycles (1,2,3,4,10/11), plus one cycle per MOC=0 cycle in state 3.
- A skipped instruction takes 4 cycles.
- RESET asserted mid-instruction aborts it; there is no partial state.

## Test plan
- Reset: hold RESET for 2 edges → STATE=0, CU_OUT=0. Release → states 1,2,3,4 follow, with MOC=1.
- MOC handshake: hold MOC=0 for 3 cycles → STATE stays 3 with IRLd=1. Raise MOC → STATE=4 on the next edge.
- Immediate ADDS: IR=0xE29A1001, A=1, B=0xFFFFFFFF, FR_Q=0 → state 11, ALU_OUT=0, FLAGS=1100, RFLd=1, FRLd=1, OP=00100.
- Register ADDS overflow: IR=0xE098C021, A=1, B=0x7FFFFFFF → state 10, ALU_OUT=0x80000000, FLAGS=0011.
- Compare: IR=0xE15A0001 (CMP), A=B=5 → RFLd=0, FRLd=1, FLAGS=1100.
- Condition fail: IR=0x0A000000 (EQ), FR_Q[2]=0 → COND_OUT=0, and 4→1. Extended op 17 with B=0x100 → ALU_OUT=0x104.
